lc3_mem_arbiter: RTL and testbench

//  Shares the single-port LC-3 Memory between two requesters: the CPU (FSM-driven MAR/MDR path)
//  and the program loader/debug port that today drives MARSpcIn/MDRSpcIn. It serialises

---
 rtl/lc3_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// Purpose: arbitrates the single-port LC-3 memory between the CPU and the loader/debug port.
// Latency: request sampled in IDLE -> mem_en next cycle -> ack MEM_LAT+2 cycles after request.
// Backpressure: one access in flight; a losing requester holds req until granted and acked.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default: loader has priority).
module lc3_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner_ld
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Down-counter only needs to hold MEM_LAT-1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_ld_q, owner_ld_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;
  logic          grant_ld;

  // Arbitration: decide which requester wins when the FSM is idle.
  always_comb begin
    grant_ld = 1'b0;
`ifdef ARB_RR_EN
    // On contention serve whichever port was not granted last.
    grant_ld = ld_req && (!cpu_req || !owner_ld_q);
`else
    // Loader owns memory during program load: it wins every contention.
    grant_ld = ld_req;
`endif
  end

  // Next-state and datapath: latch payload at grant, count read latency, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_ld_d  = owner_ld_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || ld_req) begin
          owner_ld_d = grant_ld;
          we_d       = grant_ld ? ld_we    : cpu_we;
          addr_d     = grant_ld ? ld_addr  : cpu_addr;
          wdata_d    = grant_ld ? ld_wdata : cpu_wdata;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Writes leave the held read data untouched.
          if (!we_q) begin
            if (owner_ld_q) ld_rdata_d  = mem_rdata;
            else            cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and payload registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_ld_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_ld_q  <= owner_ld_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Outputs decode straight from flops, so no input reaches an output combinationally.
  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != S_IDLE);
    owner_ld  = owner_ld_q;
    cpu_ack   = (state_q == S_DONE) && !owner_ld_q;
    ld_ack    = (state_q == S_DONE) && owner_ld_q;
    cpu_rdata = cpu_rdata_q;
    ld_rdata  = ld_rdata_q;
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: instance A (MEM_LAT=1) with a scoreboard, instance B (MEM_LAT=3).
// Expected grant order follows ARB_RR_EN when the bench is built with it defined.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_lc3_mem_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_cpu_req, a_cpu_we, a_ld_req, a_ld_we, a_cpu_ack, a_ld_ack;
  logic        a_mem_en, a_mem_we, a_busy, a_owner_ld;
  logic [15:0] a_cpu_addr, a_cpu_wdata, a_ld_addr, a_ld_wdata, a_cpu_rdata, a_ld_rdata;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_cpu_req, b_cpu_we, b_ld_req, b_ld_we, b_cpu_ack, b_ld_ack;
  logic        b_mem_en, b_mem_we, b_busy, b_owner_ld;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_ld_addr, b_ld_wdata, b_cpu_rdata, b_ld_rdata;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .ld_req(a_ld_req), .ld_we(a_ld_we), .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata),
    .ld_ack(a_ld_ack), .ld_rdata(a_ld_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner_ld(a_owner_ld));

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
    .ld_ack(b_ld_ack), .ld_rdata(b_ld_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner_ld(b_owner_ld));

  // Memory models: read data appears exactly MEM_LAT cycles after mem_en, filler otherwise.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] a_rd_q;
  logic [15:0] b_pipe [3];
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_rd_q <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 16'hDEAD;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 16'hDEAD;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mem_rdata = a_rd_q;
  assign b_mem_rdata = b_pipe[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for instance A: expected acking port and read data, in grant order.
  typedef struct packed { logic ld; logic [15:0] rdata; } exp_t;
  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [15:0] model [logic [15:0]];
  logic [15:0] exp_cpu_rd = 16'h0;
  logic [15:0] exp_ld_rd  = 16'h0;
  int          a_ld_acks  = 0;

  task automatic sb_push(input logic ld, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    if (we) model[addr] = wdata;
    else if (ld) exp_ld_rd = model[addr];
    else exp_cpu_rd = model[addr];
    sb_q.push_back({ld, ld ? exp_ld_rd : exp_cpu_rd});
  endtask

  always @(negedge clk) begin
    if (a_mem_we) chk("a_we_with_en", a_mem_en, 1);
    if (b_mem_we) chk("b_we_with_en", b_mem_en, 1);
    if (b_cpu_ack || b_ld_ack) chk("b_ack_excl", b_cpu_ack & b_ld_ack, 0);
    if (a_cpu_ack || a_ld_ack) begin
      if (a_ld_ack) a_ld_acks++;
      chk("a_ack_excl", a_cpu_ack & a_ld_ack, 0);
      chk("sb_expected_ack", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_port", a_ld_ack, mon_e.ld);
        chk("sb_rdata", a_ld_ack ? a_ld_rdata : a_cpu_rdata, mon_e.rdata);
      end
    end
  end

  // Single access on instance A: req held until own ack, dropped the cycle after.
  task automatic a_access(input logic ld, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, output int en_cyc, output int ack_cyc);
    @(posedge clk); #1;
    if (ld) begin a_ld_req = 1; a_ld_we = we; a_ld_addr = addr; a_ld_wdata = wdata; end
    else begin a_cpu_req = 1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata; end
    en_cyc = -1; ack_cyc = -1;
    for (int c = 0; c < 12 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (a_mem_en && en_cyc < 0) en_cyc = c;
      if (ld ? a_ld_ack : a_cpu_ack) ack_cyc = c;
    end
    @(posedge clk); #1;
    if (ld) a_ld_req = 0; else a_cpu_req = 0;
  endtask

  task automatic b_ld_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             output int en_cyc, output int ack_cyc);
    @(posedge clk); #1;
    b_ld_req = 1; b_ld_we = we; b_ld_addr = addr; b_ld_wdata = wdata;
    en_cyc = -1; ack_cyc = -1;
    for (int c = 0; c < 12 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (b_mem_en && en_cyc < 0) en_cyc = c;
      if (b_ld_ack) ack_cyc = c;
    end
    @(posedge clk); #1;
    b_ld_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int en, ack, en2, ack2, n, base, cnt_ack, cnt_en, last_c;
    reset = 1'b0;
    {a_cpu_req, a_cpu_we, a_ld_req, a_ld_we} = '0;
    {a_cpu_addr, a_cpu_wdata, a_ld_addr, a_ld_wdata} = '0;
    {b_cpu_req, b_cpu_we, b_ld_req, b_ld_we} = '0;
    {b_cpu_addr, b_cpu_wdata, b_ld_addr, b_ld_wdata} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_mem_en", a_mem_en, 0);
    chk("rst_a_owner", a_owner_ld, 0);
    chk("rst_a_rdata", {a_cpu_rdata, a_ld_rdata}, 0);
    chk("rst_b_outs", {b_busy, b_mem_en, b_cpu_ack, b_ld_ack, b_mem_addr}, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Reset asserted during WAIT of a CPU read aborts it.
    @(posedge clk); #1 a_cpu_req = 1; a_cpu_addr = 16'h1111; a_cpu_we = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0; a_cpu_req = 0;
    @(negedge clk);
    chk("t1_outs_zero", {a_busy, a_mem_en, a_mem_we, a_cpu_ack, a_ld_ack, a_owner_ld}, 0);
    chk("t1_addr_zero", a_mem_addr, 0);
    chk("t1_rdata_zero", a_cpu_rdata, 0);
    @(posedge clk); #1 reset = 1'b1;
    cnt_ack = 0; cnt_en = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_cpu_ack) cnt_ack++;
      if (a_mem_en || a_busy) cnt_en++;
    end
    chk("t1_no_ack", cnt_ack, 0);
    chk("t1_idle_after", cnt_en, 0);

    // CPU write then read, MEM_LAT=1.
    base = a_ld_acks;
    sb_push(0, 1, 16'h3000, 16'h1234);
    a_access(0, 1, 16'h3000, 16'h1234, en, ack);
    chk("t2_wr_en_cyc", en, 1);
    chk("t2_wr_ack_cyc", ack, 3);
    sb_push(0, 0, 16'h3000, 16'h0);
    a_access(0, 0, 16'h3000, 16'h0, en, ack);
    chk("t2_rd_en_cyc", en, 1);
    chk("t2_rd_ack_cyc", ack, 3);
    chk("t2_rd_data", a_cpu_rdata, 16'h1234);
    chk("t2_no_ld_ack", a_ld_acks - base, 0);

    // Loader read of 0xFFFF with MEM_LAT=3.
    b_ld_access(1, 16'hFFFF, 16'hBEEF, en, ack);
    chk("t3_wr_ack_cyc", ack, 5);
    b_ld_access(0, 16'hFFFF, 16'h0, en, ack);
    chk("t3_rd_en_cyc", en, 1);
    chk("t3_rd_ack_cyc", ack, 5);
    chk("t3_ld_rdata", b_ld_rdata, 16'hBEEF);
    chk("t3_cpu_rdata", b_cpu_rdata, 0);

    // Simultaneous requests; last owner made the loader first.
    sb_push(1, 1, 16'h5000, 16'h0055);
    a_access(1, 1, 16'h5000, 16'h0055, en, ack);
    if (RR) begin
      sb_push(0, 0, 16'h3000, 16'h0);
      sb_push(1, 0, 16'h5000, 16'h0);
    end else begin
      sb_push(1, 0, 16'h5000, 16'h0);
      sb_push(0, 0, 16'h3000, 16'h0);
    end
    fork
      a_access(0, 0, 16'h3000, 16'h0, en, ack);
      a_access(1, 0, 16'h5000, 16'h0, en2, ack2);
    join
    chk("t4_cpu_ack_cyc", ack, RR ? 3 : 7);
    chk("t4_ld_ack_cyc", ack2, RR ? 7 : 3);

    // Continuous requests from both ports for 10 accesses; last owner made the CPU first.
    sb_push(0, 0, 16'h3000, 16'h0);
    a_access(0, 0, 16'h3000, 16'h0, en, ack);
    for (int i = 0; i < 10; i++) sb_push(RR ? (i % 2 == 0) : 1'b1, 0, 16'h3000, 16'h0);
    @(posedge clk); #1;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h3000;
    a_ld_req  = 1; a_ld_we  = 0; a_ld_addr  = 16'h3000;
    n = 0; last_c = -1;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (a_cpu_ack || a_ld_ack) begin n++; last_c = c; end
    end
    @(posedge clk); #1 a_cpu_req = 0; a_ld_req = 0;
    chk("t5_ack_count", n, 10);
    chk("t5_last_ack_cyc", last_c, 39);

    // Request dropped in ISSUE, payload changed in WAIT.
    sb_push(0, 1, 16'h4000, 16'hA5A5);
    a_access(0, 1, 16'h4000, 16'hA5A5, en, ack);
    sb_push(0, 1, 16'h4001, 16'h5A5A);
    a_access(0, 1, 16'h4001, 16'h5A5A, en, ack);
    sb_push(0, 0, 16'h4000, 16'h0);
    @(posedge clk); #1 a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h4000;
    @(posedge clk); #1 a_cpu_req = 0;
    @(negedge clk);
    chk("t6_issue_en", a_mem_en, 1);
    chk("t6_issue_addr", a_mem_addr, 16'h4000);
    @(posedge clk); #1 a_cpu_addr = 16'h4001; a_cpu_we = 1;
    cnt_ack = 0; cnt_en = 0; ack = -1;
    for (int c = 2; c < 10; c++) begin
      @(negedge clk);
      if (a_cpu_ack) begin cnt_ack++; ack = c; end
      if (a_mem_en) cnt_en++;
    end
    a_cpu_we = 0;
    chk("t6_ack_once", cnt_ack, 1);
    chk("t6_ack_cyc", ack, 3);
    chk("t6_no_extra_en", cnt_en, 0);
    chk("t6_rdata", a_cpu_rdata, 16'hA5A5);

    repeat (5) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
